// File: rtl/nco_mon_pkg.sv
// Shared definitions for the NCO select/wave protocol monitor.
//   err_e      : error code reported on first_err
//   NUM_CHK    : number of independent checks
//   IDX_*      : bit positions of each check in err_flags / err_cnt
//   first_code : priority pick of the error code when several checks fire together
package nco_mon_pkg;

    typedef enum logic [1:0] {
        ERR_RST   = 2'd0,
        ERR_HOLD  = 2'd1,
        ERR_RESP  = 2'd2,
        ERR_STALL = 2'd3
    } err_e;

    localparam int NUM_CHK   = 4;
    localparam int IDX_RST   = 0;
    localparam int IDX_HOLD  = 1;
    localparam int IDX_RESP  = 2;
    localparam int IDX_STALL = 3;

    // Lowest index wins: rst > hold > resp > stall.
    function automatic err_e first_code(input logic [NUM_CHK-1:0] errs);
        err_e code;
        if (errs[IDX_RST])       code = ERR_RST;
        else if (errs[IDX_HOLD]) code = ERR_HOLD;
        else if (errs[IDX_RESP]) code = ERR_RESP;
        else                     code = ERR_STALL;
        return code;
    endfunction

endpackage

// File: rtl/nco_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk, resetn : clock, async active-low reset
//   inc_i       : count one when set (ignored once all-ones)
//   clr_i       : synchronous clear, wins over inc_i
//   cnt_o       : current count
module nco_mon_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/nco_protocol_monitor.sv
// Protocol monitor for the NCO select/wave interface. Samples signal_out and
// wave_out every clock and checks: wave zero right after reset, minimum select
// hold time, select-to-wave response latency, and wave stall.
//   clk, resetn  : clock, async active-low reset
//   mon_en       : checks active; when low sampling continues but windows are cleared
//   clr          : synchronous clear of flags, counts and first-error record
//   signal_out   : observed NCO select
//   wave_out     : observed NCO wave
//   err_flags    : sticky {stall,resp,hold,rst}
//   err_cnt      : saturating per-check counts, same order as err_flags
//   first_err    : code of the first error (nco_mon_pkg::err_e)
//   first_valid  : first_err / first_time hold a captured error
//   first_time   : cycle stamp of the first error
module nco_protocol_monitor
    import nco_mon_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int WAVE_W     = 8,
    parameter int MIN_HOLD   = 31,
    parameter int RESP_LAT   = 2,
    parameter int RESP_EXACT = 1,
    parameter int STALL_LIM  = 64,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mon_en,
    input  logic                     clr,
    input  logic [SEL_W-1:0]         signal_out,
    input  logic [WAVE_W-1:0]        wave_out,
    output logic [NUM_CHK-1:0]       err_flags,
    output logic [NUM_CHK*CNT_W-1:0] err_cnt,
    output logic [1:0]               first_err,
    output logic                     first_valid,
    output logic [31:0]              first_time
);

    localparam int HOLD_W  = $clog2(MIN_HOLD + 1);
    localparam int RESP_W  = $clog2(RESP_LAT + 1);
    localparam int STALL_W = (STALL_LIM > 0) ? $clog2(STALL_LIM + 1) : 1;

    logic                prev_valid_q;
    logic [SEL_W-1:0]    prev_sel_q;
    logic [WAVE_W-1:0]   prev_wave_q;
    logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
    logic [RESP_W-1:0]   resp_cnt_q,  resp_cnt_d;
    logic                resp_seen_q, resp_seen_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [NUM_CHK-1:0]  flags_q,     flags_d;
    err_e                first_err_q, first_err_d;
    logic                first_valid_q, first_valid_d;
    logic [31:0]         first_time_q,  first_time_d;
    logic [31:0]         cyc_cnt;

    logic                sel_chg;
    logic                wave_chg;
    logic                err_rst;
    logic                err_hold;
    logic                err_resp;
    logic                err_stall;
    logic [NUM_CHK-1:0]  errs;

    // No previous sample exists in the first cycle after reset, so nothing counts as a change.
    assign sel_chg  = prev_valid_q && (signal_out != prev_sel_q);
    assign wave_chg = prev_valid_q && (wave_out != prev_wave_q);
    assign err_rst  = mon_en && !prev_valid_q && (wave_out != '0);

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        err_hold   = 1'b0;
        if (!mon_en) begin
            hold_cnt_d = '0;
        end else if (sel_chg) begin
            err_hold   = (hold_cnt_q != '0);
            hold_cnt_d = HOLD_W'(MIN_HOLD);
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
    end

    // The old window is judged first (wave_chg in this cycle belongs to it),
    // then a select change opens a fresh one. resp_seen limits exact mode to
    // one error per window.
    always_comb begin
        resp_cnt_d  = resp_cnt_q;
        resp_seen_d = resp_seen_q;
        err_resp    = 1'b0;
        if (!mon_en) begin
            resp_cnt_d  = '0;
            resp_seen_d = 1'b0;
        end else begin
            if (resp_cnt_q != '0) begin
                if (RESP_EXACT != 0) begin
                    if (!resp_seen_q) begin
                        if (resp_cnt_q == RESP_W'(1)) begin
                            err_resp = !wave_chg;
                        end else if (wave_chg) begin
                            err_resp    = 1'b1;
                            resp_seen_d = 1'b1;
                        end
                    end
                    resp_cnt_d = resp_cnt_q - RESP_W'(1);
                end else begin
                    if (wave_chg) begin
                        resp_cnt_d = '0;
                    end else begin
                        err_resp   = (resp_cnt_q == RESP_W'(1));
                        resp_cnt_d = resp_cnt_q - RESP_W'(1);
                    end
                end
            end
            if (sel_chg) begin
                resp_cnt_d  = RESP_W'(RESP_LAT);
                resp_seen_d = 1'b0;
            end
        end
    end

    // Counter parks at the limit so a long stall reports only once.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        err_stall   = 1'b0;
        if (!mon_en || (STALL_LIM == 0)) begin
            stall_cnt_d = '0;
        end else if (wave_chg) begin
            stall_cnt_d = '0;
        end else if (prev_valid_q && (stall_cnt_q != STALL_W'(STALL_LIM))) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
            err_stall   = (stall_cnt_d == STALL_W'(STALL_LIM));
        end
    end

    always_comb begin
        errs            = '0;
        errs[IDX_RST]   = err_rst;
        errs[IDX_HOLD]  = err_hold;
        errs[IDX_RESP]  = err_resp;
        errs[IDX_STALL] = err_stall;
    end

    always_comb begin
        flags_d       = flags_q | errs;
        first_err_d   = first_err_q;
        first_valid_d = first_valid_q;
        first_time_d  = first_time_q;
        if (clr) begin
            flags_d       = '0;
            first_err_d   = ERR_RST;
            first_valid_d = 1'b0;
            first_time_d  = '0;
        end else if (!first_valid_q && (errs != '0)) begin
            first_err_d   = first_code(errs);
            first_valid_d = 1'b1;
            first_time_d  = cyc_cnt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_valid_q  <= 1'b0;
            prev_sel_q    <= '0;
            prev_wave_q   <= '0;
            hold_cnt_q    <= '0;
            resp_cnt_q    <= '0;
            resp_seen_q   <= 1'b0;
            stall_cnt_q   <= '0;
            flags_q       <= '0;
            first_err_q   <= ERR_RST;
            first_valid_q <= 1'b0;
            first_time_q  <= '0;
        end else begin
            prev_valid_q  <= 1'b1;
            prev_sel_q    <= signal_out;
            prev_wave_q   <= wave_out;
            hold_cnt_q    <= hold_cnt_d;
            resp_cnt_q    <= resp_cnt_d;
            resp_seen_q   <= resp_seen_d;
            stall_cnt_q   <= stall_cnt_d;
            flags_q       <= flags_d;
            first_err_q   <= first_err_d;
            first_valid_q <= first_valid_d;
            first_time_q  <= first_time_d;
        end
    end

    for (genvar c = 0; c < NUM_CHK; c++) begin : g_cnt
        nco_mon_sat_cnt #(
            .WIDTH (CNT_W)
        ) u_err_cnt (
            .clk    (clk),
            .resetn (resetn),
            .inc_i  (errs[c]),
            .clr_i  (clr),
            .cnt_o  (err_cnt[c*CNT_W +: CNT_W])
        );
    end

    // Free-running time base; not affected by clr so stamps stay comparable.
    nco_mon_sat_cnt #(
        .WIDTH (32)
    ) u_cyc_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc_i  (1'b1),
        .clr_i  (1'b0),
        .cnt_o  (cyc_cnt)
    );

    assign err_flags   = flags_q;
    assign first_err   = first_err_q;
    assign first_valid = first_valid_q;
    assign first_time  = first_time_q;

endmodule

// File: tb/tb_nco_protocol_monitor.sv
module tb_nco_protocol_monitor;
    import nco_mon_pkg::*;

    localparam int MIN_HOLD  = 31;
    localparam int RESP_LAT  = 2;
    localparam int STALL_LIM = 64;
    localparam int HMAX      = 8192;

    logic        clk;
    logic        resetn;
    logic        mon_en;
    logic        clr;
    logic [2:0]  signal_out;
    logic [7:0]  wave_out;

    logic [3:0]  flags_x, flags_w;
    logic [31:0] cnt_x, cnt_w;
    logic [1:0]  fe_x, fe_w;
    logic        fv_x, fv_w;
    logic [31:0] ft_x, ft_w;

    nco_protocol_monitor #(.RESP_EXACT(1)) dut_x (
        .clk(clk), .resetn(resetn), .mon_en(mon_en), .clr(clr),
        .signal_out(signal_out), .wave_out(wave_out),
        .err_flags(flags_x), .err_cnt(cnt_x), .first_err(fe_x),
        .first_valid(fv_x), .first_time(ft_x)
    );

    nco_protocol_monitor #(.RESP_EXACT(0)) dut_w (
        .clk(clk), .resetn(resetn), .mon_en(mon_en), .clr(clr),
        .signal_out(signal_out), .wave_out(wave_out),
        .err_flags(flags_w), .err_cnt(cnt_w), .first_err(fe_w),
        .first_valid(fv_w), .first_time(ft_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: keeps the sample history since reset and derives each
    // check directly from the rules (distance to last select change, any wave
    // change inside the window, distance since last wave change).
    logic [2:0]  h_sel  [HMAX];
    logic [7:0]  h_wave [HMAX];
    int          k;
    int          last_dis;
    int          last_wchg;
    logic [3:0]  m_flags [2];
    logic [7:0]  m_cnt   [2][4];
    logic        m_fv    [2];
    logic [1:0]  m_fe    [2];
    logic [31:0] m_ft    [2];

    function automatic bit schg_at(input int j);
        return (j > 0) && (h_sel[j] != h_sel[j-1]);
    endfunction

    function automatic bit wchg_at(input int j);
        return (j > 0) && (h_wave[j] != h_wave[j-1]);
    endfunction

    function automatic int prev_schg(input int kk);
        for (int j = kk - 1; j >= 0 && j >= kk - 64; j--)
            if (schg_at(j)) return j;
        return -1;
    endfunction

    task automatic model_reset();
        k         = 0;
        last_dis  = -1;
        last_wchg = -1;
        for (int i = 0; i < 2; i++) begin
            m_flags[i] = '0;
            m_fv[i]    = 1'b0;
            m_fe[i]    = '0;
            m_ft[i]    = '0;
            for (int c = 0; c < 4; c++) m_cnt[i][c] = '0;
        end
    endtask

    task automatic model_step(input logic [2:0] s, input logic [7:0] wv,
                              input logic en, input logic c_clr);
        logic [3:0] e [2];
        int  j, d, base;
        bit  w, early;
        if (k >= HMAX - 1) begin
            $display("FAIL model history overflow at %0d", k);
            $fatal(1);
        end
        h_sel[k]  = s;
        h_wave[k] = wv;
        if (!en) last_dis = k;
        w = wchg_at(k);
        if (w) last_wchg = k;
        base = (last_wchg > last_dis) ? last_wchg : last_dis;
        if (base < 0) base = 0;
        for (int i = 0; i < 2; i++) begin
            e[i] = '0;
            if (en) begin
                e[i][0] = (k == 0) && (wv != 8'h00);
                j = prev_schg(k);
                if (j >= 0 && j > last_dis) begin
                    d = k - j;
                    e[i][1] = schg_at(k) && (d <= MIN_HOLD);
                    if (d <= RESP_LAT) begin
                        early = 0;
                        for (int m = j + 1; m < k; m++) if (wchg_at(m)) early = 1;
                        if (i == 0)
                            e[i][2] = !early && ((d < RESP_LAT && w) || (d == RESP_LAT && !w));
                        else
                            e[i][2] = !early && (d == RESP_LAT) && !w;
                    end
                end
                e[i][3] = ((k - base) == STALL_LIM);
            end
            if (c_clr) begin
                m_flags[i] = '0;
                m_fv[i]    = 1'b0;
                m_fe[i]    = '0;
                m_ft[i]    = '0;
                for (int c = 0; c < 4; c++) m_cnt[i][c] = '0;
            end else begin
                for (int c = 0; c < 4; c++) begin
                    if (e[i][c]) begin
                        m_flags[i][c] = 1'b1;
                        if (m_cnt[i][c] != 8'hFF) m_cnt[i][c] = m_cnt[i][c] + 8'd1;
                    end
                end
                if (!m_fv[i] && e[i] != 4'b0) begin
                    m_fv[i] = 1'b1;
                    m_ft[i] = k;
                    for (int c = 3; c >= 0; c--) if (e[i][c]) m_fe[i] = 2'(c);
                end
            end
        end
        k++;
    endtask

    task automatic compare_model();
        chk("x.flags", {28'b0, flags_x}, {28'b0, m_flags[0]});
        chk("x.cnt",   cnt_x, {m_cnt[0][3], m_cnt[0][2], m_cnt[0][1], m_cnt[0][0]});
        chk("x.fv",    {31'b0, fv_x}, {31'b0, m_fv[0]});
        chk("x.fe",    {30'b0, fe_x}, {30'b0, m_fe[0]});
        chk("x.ft",    ft_x, m_ft[0]);
        chk("w.flags", {28'b0, flags_w}, {28'b0, m_flags[1]});
        chk("w.cnt",   cnt_w, {m_cnt[1][3], m_cnt[1][2], m_cnt[1][1], m_cnt[1][0]});
        chk("w.fv",    {31'b0, fv_w}, {31'b0, m_fv[1]});
        chk("w.fe",    {30'b0, fe_w}, {30'b0, m_fe[1]});
        chk("w.ft",    ft_w, m_ft[1]);
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic cyc(input logic [2:0] s, input logic [7:0] wv,
                       input logic en, input logic c_clr);
        signal_out = s;
        wave_out   = wv;
        mon_en     = en;
        clr        = c_clr;
        @(posedge clk);
        model_step(s, wv, en, c_clr);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset(input logic [2:0] s, input logic [7:0] wv);
        signal_out = s;
        wave_out   = wv;
        mon_en     = 1'b1;
        clr        = 1'b0;
        #2 resetn  = 1'b0;
        @(negedge clk);
        model_reset();
        compare_model();
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [7:0]  wave;
        logic        en;
        logic        c_clr;
        int          reps;
        logic [3:0]  ef;
        logic [31:0] ec;
        logic        efv;
        logic [1:0]  efe;
        logic [31:0] eft;
        logic [3:0]  ef_w;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [2:0] s;
        logic [7:0] w;
        int         wmode;
        int         off;

        resetn     = 1'b0;
        mon_en     = 1'b1;
        clr        = 1'b0;
        signal_out = '0;
        wave_out   = '0;
        model_reset();

        tbl[0]  = '{3'd0, 8'h05, 1'b1, 1'b0,   1, 4'b0001, 32'h00000001, 1'b1, 2'd0,  0, 4'b0001};
        tbl[1]  = '{3'd0, 8'h05, 1'b1, 1'b1,   1, 4'b0000, 32'h00000000, 1'b0, 2'd0,  0, 4'b0000};
        tbl[2]  = '{3'd3, 8'h05, 1'b1, 1'b0,   1, 4'b0000, 32'h00000000, 1'b0, 2'd0,  0, 4'b0000};
        tbl[3]  = '{3'd3, 8'h05, 1'b1, 1'b0,   1, 4'b0000, 32'h00000000, 1'b0, 2'd0,  0, 4'b0000};
        tbl[4]  = '{3'd3, 8'h06, 1'b1, 1'b0,   1, 4'b0000, 32'h00000000, 1'b0, 2'd0,  0, 4'b0000};
        tbl[5]  = '{3'd3, 8'h06, 1'b1, 1'b0,  40, 4'b0000, 32'h00000000, 1'b0, 2'd0,  0, 4'b0000};
        tbl[6]  = '{3'd5, 8'h06, 1'b1, 1'b0,   1, 4'b0000, 32'h00000000, 1'b0, 2'd0,  0, 4'b0000};
        tbl[7]  = '{3'd5, 8'h07, 1'b1, 1'b0,   1, 4'b0100, 32'h00010000, 1'b1, 2'd2, 46, 4'b0000};
        tbl[8]  = '{3'd5, 8'h07, 1'b1, 1'b0,   1, 4'b0100, 32'h00010000, 1'b1, 2'd2, 46, 4'b0000};
        tbl[9]  = '{3'd6, 8'h07, 1'b1, 1'b0,   1, 4'b0110, 32'h00010100, 1'b1, 2'd2, 46, 4'b0010};
        tbl[10] = '{3'd6, 8'h07, 1'b1, 1'b0,   2, 4'b0110, 32'h00020100, 1'b1, 2'd2, 46, 4'b0110};
        tbl[11] = '{3'd6, 8'h07, 1'b1, 1'b0,  59, 4'b0110, 32'h00020100, 1'b1, 2'd2, 46, 4'b0110};
        tbl[12] = '{3'd6, 8'h07, 1'b1, 1'b0,   1, 4'b1110, 32'h01020100, 1'b1, 2'd2, 46, 4'b1110};
        tbl[13] = '{3'd6, 8'h07, 1'b1, 1'b0, 136, 4'b1110, 32'h01020100, 1'b1, 2'd2, 46, 4'b1110};
        tbl[14] = '{3'd6, 8'h07, 1'b1, 1'b1,   1, 4'b0000, 32'h00000000, 1'b0, 2'd0,  0, 4'b0000};
        tbl[15] = '{3'd7, 8'h07, 1'b0, 1'b0,   1, 4'b0000, 32'h00000000, 1'b0, 2'd0,  0, 4'b0000};
        tbl[16] = '{3'd0, 8'h07, 1'b0, 1'b0,   1, 4'b0000, 32'h00000000, 1'b0, 2'd0,  0, 4'b0000};
        tbl[17] = '{3'd0, 8'h07, 1'b1, 1'b0,   1, 4'b0000, 32'h00000000, 1'b0, 2'd0,  0, 4'b0000};
        tbl[18] = '{3'd1, 8'h07, 1'b1, 1'b0,   2, 4'b0000, 32'h00000000, 1'b0, 2'd0,  0, 4'b0000};
        tbl[19] = '{3'd1, 8'h07, 1'b1, 1'b0,   1, 4'b0100, 32'h00010000, 1'b1, 2'd2, 253, 4'b0100};

        @(negedge clk);
        do_reset(3'd0, 8'h05);
        for (int r = 0; r < 20; r++) begin
            for (int n = 0; n < tbl[r].reps; n++)
                cyc(tbl[r].sel, tbl[r].wave, tbl[r].en, tbl[r].c_clr);
            chk($sformatf("vec%0d.flags", r), {28'b0, flags_x}, {28'b0, tbl[r].ef});
            chk($sformatf("vec%0d.cnt", r), cnt_x, tbl[r].ec);
            chk($sformatf("vec%0d.fv", r), {31'b0, fv_x}, {31'b0, tbl[r].efv});
            chk($sformatf("vec%0d.fe", r), {30'b0, fe_x}, {30'b0, tbl[r].efe});
            chk($sformatf("vec%0d.ft", r), ft_x, tbl[r].eft);
            chk($sformatf("vec%0d.flags_w", r), {28'b0, flags_w}, {28'b0, tbl[r].ef_w});
        end

        // Reset lands inside an open response window: nothing may be reported.
        cyc(3'd2, 8'h07, 1'b1, 1'b0);
        do_reset(3'd2, 8'h00);
        for (int n = 0; n < 3; n++) cyc(3'd2, 8'h00, 1'b1, 1'b0);
        chk("rstmid.flags_x", {28'b0, flags_x}, 32'h0);
        chk("rstmid.flags_w", {28'b0, flags_w}, 32'h0);

        // Select toggling every cycle: hold count must saturate, then clr wipes all.
        do_reset(3'd0, 8'h00);
        for (int n = 0; n < 310; n++)
            cyc(3'(n & 1), 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        chk("sat.hold_x", {24'b0, cnt_x[15:8]}, 32'd255);
        chk("sat.hold_w", {24'b0, cnt_w[15:8]}, 32'd255);
        cyc(3'd0, 8'h00, 1'b1, 1'b1);
        chk("sat.clr_cnt", cnt_x, 32'h0);
        chk("sat.clr_flags", {28'b0, flags_x}, 32'h0);
        chk("sat.clr_fv", {31'b0, fv_x}, 32'h0);

        // Randomised traffic against the model.
        s   = 3'($urandom_range(0, 7));
        w   = 8'($urandom_range(0, 255));
        off = 0;
        wmode = 0;
        do_reset(s, 8'h00);
        w = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) wmode = $urandom_range(0, 2);
            if ($urandom_range(0, 23) == 0) s = s + 3'($urandom_range(1, 7));
            if ((wmode == 0 && $urandom_range(0, 1) == 0) ||
                (wmode == 1 && $urandom_range(0, 11) == 0))
                w = w + 8'($urandom_range(1, 255));
            if (off > 0) off--;
            else if ($urandom_range(0, 249) == 0) off = $urandom_range(1, 5);
            if ($urandom_range(0, 899) == 0)
                do_reset(s, ($urandom_range(0, 3) == 0) ? w : 8'h00);
            else
                cyc(s, w, (off == 0), ($urandom_range(0, 299) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
